input_debounce: RTL

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 107 ++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// Per-channel switch debouncer: two-flop synchronizer, then q follows only after CNT_MAX stable cycles.
// Define DEBOUNCE_EDGE_EN to add registered one-cycle rise/fall pulses derived from q.
module input_debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          q_r;
    logic          q_nxt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        q_r   <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        q_r   <= q_nxt;
      end
    end

    // The counter sits at 0 on the edge COUNT is entered, so acceptance lands CNT_MAX edges later.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      q_nxt     = q_r;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (s2[i] != q_r) begin
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          if (s2[i] == q_r) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            q_nxt     = s2[i];
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign q[i] = q_r;
  end

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] q_d;

  // q_d resets together with q, so a reset never looks like a 1->0 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d  <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      q_d  <= q;
      rise <= q & ~q_d;
      fall <= ~q & q_d;
    end
  end
`endif

endmodule
